// File: rtl/ssenc_pkg.sv
// Shared types, constants and the glyph table for the segment-to-glyph encoder.
package ssenc_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [4:0] code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_STABLE = 2'd2
    } state_t;

    localparam code_t CODE_NONE  = 5'h1F;
    localparam seg_t  SEG_BLANK  = 7'h00;
    localparam int    NUM_GLYPHS = 26;

    // Entry n is the segment pattern (g..a) that displays glyph code n.
    localparam seg_t GLYPH_TABLE [NUM_GLYPHS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h6F, 7'h76, 7'h10, 7'h1E,
        7'h38, 7'h54, 7'h50, 7'h78, 7'h6E, 7'h53
    };

endpackage

// File: rtl/ssenc_lut.sv
// Combinational reverse lookup: segment pattern to glyph code plus known/blank flags.
module ssenc_lut
    import ssenc_pkg::*;
(
    input  seg_t  i_seg,
    output code_t o_code,
    output logic  o_known,
    output logic  o_blank
);

    always_comb begin
        o_code  = CODE_NONE;
        o_known = 1'b0;
        o_blank = (i_seg == SEG_BLANK);
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (i_seg == GLYPH_TABLE[i]) begin
                o_code  = code_t'(i);
                o_known = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssenc_stream.sv
// Glitch-filtered segment-pattern to glyph-code event stream.
// Define SSENC_ERRCNT_EN to add the saturating unknown-glyph event counter err_count.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | no sample counted since reset (cnt = 0)
// ST_COUNT  | candidate seen 1..STABLE_CYCLES-1 times in a row
// ST_STABLE | candidate stable; no further events until it changes
module ssenc_stream
    import ssenc_pkg::*;
#(
    parameter int STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [4:0] code_out,
    output logic       code_known,
    output logic       code_blank,
    output logic       code_valid,
    input  logic       code_ready
`ifdef SSENC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    state_t           r_state;
    seg_t             r_cand;
    logic [CNT_W-1:0] r_cnt;
    seg_t             r_last;
    logic             r_have;
    code_t            r_code;
    logic             r_known;
    logic             r_blank;
    logic             r_valid;

    logic             w_accept;
    logic             w_same;
    seg_t             w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_fire;
    code_t            w_lut_code;
    logic             w_lut_known;
    logic             w_lut_blank;

    assign seg_ready = !r_valid || code_ready;
    assign w_accept  = seg_valid && seg_ready;
    assign w_same    = (seg_in == r_cand);

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_accept) begin
            if (w_same) begin
                if (r_state != ST_STABLE) w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_cand_nxt = seg_in;
                w_cnt_nxt  = CNT_W'(1);
            end
        end
    end

    // Fire only on the transition into stability, and only for a new pattern.
    assign w_fire = w_accept && (w_cnt_nxt == CNT_MAX)
                    && ((r_state != ST_STABLE) || !w_same)
                    && (!r_have || (w_cand_nxt != r_last));

    // Looking up the next candidate lets a STABLE_CYCLES=1 build load the
    // freshly accepted pattern on the same edge.
    ssenc_lut u_lut (
        .i_seg   (w_cand_nxt),
        .o_code  (w_lut_code),
        .o_known (w_lut_known),
        .o_blank (w_lut_blank)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cand  <= SEG_BLANK;
            r_cnt   <= '0;
            r_last  <= SEG_BLANK;
            r_have  <= 1'b0;
            r_code  <= 5'h00;
            r_known <= 1'b0;
            r_blank <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_MAX)  r_state <= ST_STABLE;
            else if (w_cnt_nxt == '0) r_state <= ST_IDLE;
            else                       r_state <= ST_COUNT;

            if (w_fire) begin
                r_code  <= w_lut_code;
                r_known <= w_lut_known;
                r_blank <= w_lut_blank;
                r_valid <= 1'b1;
                r_last  <= w_cand_nxt;
                r_have  <= 1'b1;
            end else if (r_valid && code_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign code_out   = r_code;
    assign code_known = r_known;
    assign code_blank = r_blank;
    assign code_valid = r_valid;

`ifdef SSENC_ERRCNT_EN
    logic [7:0] r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 8'h00;
        end else if (w_fire && !w_lut_known && !w_lut_blank && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_count = r_err;
`endif

endmodule

// File: tb/tb_ssenc_stream.sv
// Directed bench for ssenc_stream: run-length event model checked every cycle plus literal spot checks.
module tb_ssenc_stream;

    localparam int STABLE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       seg_valid = 1'b0;
    logic       code_ready = 1'b0;
    logic       seg_ready;
    logic [4:0] code_out;
    logic       code_known;
    logic       code_blank;
    logic       code_valid;
`ifdef SSENC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    ssenc_stream #(.STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .code_out   (code_out),
        .code_known (code_known),
        .code_blank (code_blank),
        .code_valid (code_valid),
        .code_ready (code_ready)
`ifdef SSENC_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int ev_cnt = 0;
    int e0 = 0;
    bit chk_en = 1'b0;

    logic [6:0] tbl [26] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h6F, 7'h76, 7'h10, 7'h1E,
        7'h38, 7'h54, 7'h50, 7'h78, 7'h6E, 7'h53
    };

    function automatic logic [6:0] lookup(input logic [6:0] p);
        logic [6:0] r;
        r = {5'h1F, 1'b0, (p == 7'h00)};
        for (int i = 0; i < 26; i++)
            if (tbl[i] == p) r = {i[4:0], 1'b1, 1'b0};
        return r;
    endfunction

    // Model: length of the current run of identical accepted samples.
    logic [6:0] m_run_pat;
    int         m_run_len;
    logic [6:0] m_last;
    bit         m_have;
    logic       m_valid;
    logic [4:0] m_code;
    logic       m_known;
    logic       m_blank;
    int         m_err;
    bit         m_acc;
    bit         m_fire;
    logic [6:0] m_lk;

    always @(posedge clk) begin
        if (reset) begin
            m_run_pat = 7'h00; m_run_len = 0; m_last = 7'h00; m_have = 0;
            m_valid = 0; m_code = 5'h00; m_known = 0; m_blank = 0; m_err = 0;
        end else begin
            m_acc  = seg_valid && (!m_valid || code_ready);
            m_fire = 0;
            if (m_acc) begin
                if (seg_in == m_run_pat) begin
                    if (m_run_len < 1000) m_run_len++;
                end else begin
                    m_run_pat = seg_in;
                    m_run_len = 1;
                end
                m_fire = (m_run_len == STABLE) && (!m_have || m_run_pat != m_last);
            end
            if (m_fire) begin
                m_lk = lookup(m_run_pat);
                {m_code, m_known, m_blank} = m_lk;
                m_valid = 1;
                m_last = m_run_pat;
                m_have = 1;
                if (!m_known && !m_blank && m_err < 255) m_err++;
            end else if (m_valid && code_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("seg_ready",  32'(seg_ready),  32'(!m_valid || code_ready));
            chk("code_valid", 32'(code_valid), 32'(m_valid));
            chk("code_out",   32'(code_out),   32'(m_code));
            chk("code_known", 32'(code_known), 32'(m_known));
            chk("code_blank", 32'(code_blank), 32'(m_blank));
`ifdef SSENC_ERRCNT_EN
            chk("err_count",  32'(err_count),  32'(m_err));
`endif
        end
    end

    always @(negedge clk)
        if (chk_en && !reset && code_valid && code_ready) ev_cnt++;

    task automatic step(input logic [6:0] p, input logic v, input logic r);
        seg_in = p; seg_valid = v; code_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2;
        reset = 1'b1;
        step(7'h00, 0, 1);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_out",   32'(code_out), 0);

        // Basic three-sample stabilisation
        step(7'h5B, 1, 1); step(7'h5B, 1, 1);
        chk("s1_early", 32'(code_valid), 0);
        step(7'h5B, 1, 1);
        chk("s1_valid", 32'(code_valid), 1);
        chk("s1_code",  32'(code_out), 32'h02);
        chk("s1_known", 32'(code_known), 1);
        step(7'h5B, 1, 1);
        chk("s1_onecyc", 32'(code_valid), 0);
        chk("s1_events", 32'(ev_cnt), 1);

        // Glitch restarts the count
        e0 = ev_cnt;
        step(7'h7D, 1, 1); step(7'h7D, 1, 1); step(7'h7C, 1, 1);
        step(7'h7D, 1, 1); step(7'h7D, 1, 1);
        chk("s2_none", 32'(ev_cnt - e0 + int'(code_valid)), 0);
        step(7'h7D, 1, 1);
        chk("s2_valid", 32'(code_valid), 1);
        chk("s2_code",  32'(code_out), 32'h06);
        step(7'h7D, 0, 1);
        chk("s2_events", 32'(ev_cnt - e0), 1);

        // Blank and unknown patterns
        repeat (3) step(7'h00, 1, 1);
        chk("s3_blank", 32'(code_blank), 1);
        chk("s3_bcode", 32'(code_out), 32'h1F);
        step(7'h00, 0, 1);
        repeat (3) step(7'h09, 1, 1);
        chk("s3_ucode", 32'({code_out, code_known, code_blank}), 32'({5'h1F, 2'b00}));
`ifdef SSENC_ERRCNT_EN
        chk("s3_err", 32'(err_count), 1);
`endif
        step(7'h09, 0, 1);

        // Back-pressure: event held while consumer stalls
        step(7'h3F, 1, 1); step(7'h3F, 1, 1); step(7'h3F, 1, 0);
        chk("s4_valid", 32'(code_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step(7'h6D, 1, 0);
            chk("s4_stall_rdy", 32'(seg_ready), 0);
            chk("s4_stall_out", 32'({code_valid, code_out, code_known}), 32'({1'b1, 5'h00, 1'b1}));
        end
        seg_in = 7'h6D; seg_valid = 1'b1; code_ready = 1'b1;
        #1;
        chk("s4_release", 32'(seg_ready), 1);
        step(7'h6D, 1, 1);
        chk("s4_cleared", 32'(code_valid), 0);

        // Long stable run yields one event, then a new glyph
        e0 = ev_cnt;
        for (int i = 0; i < 13; i++) begin
            step(7'h53, 1, 1);
            if (i == 2) chk("s5_code", 32'(code_out), 32'h19);
        end
        step(7'h53, 0, 1);
        chk("s5_events", 32'(ev_cnt - e0), 1);
        repeat (3) step(7'h6F, 1, 1);
        chk("s5_code2", 32'({code_valid, code_out}), 32'({1'b1, 5'h10}));
        step(7'h6F, 0, 1);

        // Same glyph re-stabilising after a glitch, with idle gaps
        e0 = ev_cnt;
        step(7'h4F, 1, 1); step(7'h6F, 1, 1); step(7'h6F, 0, 1);
        step(7'h6F, 1, 1); step(7'h11, 0, 0); step(7'h6F, 1, 1);
        step(7'h6F, 1, 1);
        chk("s6_noevent", 32'(ev_cnt - e0 + int'(code_valid)), 0);

        // Mid-run reset restarts the count and forgets the last glyph
        step(7'h3F, 1, 1); step(7'h3F, 1, 1);
        reset = 1'b1;
        step(7'h3F, 1, 1);
        reset = 1'b0;
        chk("s7_rst", 32'({code_valid, code_out, code_known, code_blank}), 0);
        step(7'h3F, 1, 1); step(7'h3F, 1, 1);
        chk("s7_none", 32'(code_valid), 0);
        step(7'h3F, 1, 1);
        chk("s7_event", 32'({code_valid, code_out, code_known}), 32'({1'b1, 5'h00, 1'b1}));
        step(7'h3F, 0, 1);
        step(7'h3F, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
